// File: rtl/packet_arb_pkg.sv
// Shared types and helpers for the packet stream arbiter and its round-robin picker.
package packet_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PACKET = 2'd1,
        ABORT  = 2'd2
    } arb_state_t;

    // Fill value replicated across the data bus for the synthetic EOP of an aborted packet
    localparam logic ABORT_FILL_BIT = 1'b0;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, cyclically.
module rr_arbiter
    import packet_arb_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS = 4,
    localparam int unsigned CH_W       = ch_width(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] i_req,
    input  logic [CH_W-1:0]       i_ptr,
    output logic [NUM_INPUTS-1:0] o_grant_oh,
    output logic [CH_W-1:0]       o_grant_idx,
    output logic                  o_any_req
);

    always_comb begin
        logic          w_found;
        logic [CH_W-1:0] w_idx;
        w_found     = 1'b0;
        w_idx       = '0;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            w_idx = CH_W'((32'(i_ptr) + k) % NUM_INPUTS);
            if (!w_found && i_req[w_idx]) begin
                w_found            = 1'b1;
                o_grant_oh[w_idx]  = 1'b1;
                o_grant_idx        = w_idx;
            end
        end
        o_any_req = w_found;
    end

endmodule

// File: rtl/packet_stream_arbiter.sv
// Packet-granular round-robin arbiter onto one Avalon-ST sink, with stall abort and
// sticky timeout/orphan error flags.
module packet_stream_arbiter
    import packet_arb_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS    = 4,
    parameter  int unsigned DATA_WIDTH    = 256,
    parameter  int unsigned STALL_TIMEOUT = 1024,
    localparam int unsigned CH_W          = ch_width(NUM_INPUTS)
) (
    input  logic                             clock_clk,
    input  logic                             reset_reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] asi_in_data,
    input  logic [NUM_INPUTS-1:0]            asi_in_valid,
    input  logic [NUM_INPUTS-1:0]            asi_in_startofpacket,
    input  logic [NUM_INPUTS-1:0]            asi_in_endofpacket,
    output logic [NUM_INPUTS-1:0]            asi_in_ready,
    output logic [DATA_WIDTH-1:0]            aso_out0_data,
    output logic                             aso_out0_valid,
    input  logic                             aso_out0_ready,
    output logic                             aso_out0_startofpacket,
    output logic                             aso_out0_endofpacket,
    output logic [CH_W-1:0]                  aso_out0_channel,
    output logic [NUM_INPUTS-1:0]            err_timeout,
    output logic [NUM_INPUTS-1:0]            err_orphan,
    input  logic                             status_clear
);

    localparam int unsigned      CNT_W      = $clog2(STALL_TIMEOUT);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_TIMEOUT - 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_INPUTS - 1);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [CH_W-1:0]         r_grant;
    logic [NUM_INPUTS-1:0]   r_grant_oh;
    logic [CH_W-1:0]         r_rr_ptr;
    logic [CNT_W-1:0]        r_stall_cnt;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_sop;
    logic                    r_out_eop;
    logic [CH_W-1:0]         r_out_ch;
    logic [NUM_INPUTS-1:0]   r_err_timeout;
    logic [NUM_INPUTS-1:0]   r_err_orphan;

    logic [DATA_WIDTH-1:0]   w_src_data [NUM_INPUTS];
    logic [NUM_INPUTS-1:0]   w_arb_oh;
    logic [CH_W-1:0]         w_arb_idx;
    logic                    w_any_req;
    logic                    w_out_free;
    logic                    w_grant_valid;
    logic                    w_grant_sop;
    logic                    w_grant_eop;
    logic                    w_accept;
    logic                    w_load_abort;
    logic                    w_grant_load;
    logic                    w_ptr_load;
    logic                    w_stall_inc;
    logic                    w_stall_clr;
    logic [NUM_INPUTS-1:0]   w_timeout_set;
    logic [NUM_INPUTS-1:0]   w_orphan_set;

    rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_rr_arbiter (
        .i_req       (asi_in_valid & asi_in_startofpacket),
        .i_ptr       (r_rr_ptr),
        .o_grant_oh  (w_arb_oh),
        .o_grant_idx (w_arb_idx),
        .o_any_req   (w_any_req)
    );

    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            w_src_data[i] = asi_in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_out_free    = !r_out_valid || aso_out0_ready;
    assign w_grant_valid = |(asi_in_valid & r_grant_oh);
    assign w_grant_sop   = |(asi_in_startofpacket & r_grant_oh);
    assign w_grant_eop   = |(asi_in_endofpacket & r_grant_oh);

    // State register
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, source readies and datapath enables
    always_comb begin
        w_state_nxt   = r_state;
        asi_in_ready  = '0;
        w_accept      = 1'b0;
        w_load_abort  = 1'b0;
        w_grant_load  = 1'b0;
        w_ptr_load    = 1'b0;
        w_stall_inc   = 1'b0;
        w_stall_clr   = 1'b0;
        w_timeout_set = '0;
        w_orphan_set  = '0;
        unique case (r_state)
            IDLE: begin
                // Headless beats are drained here so they cannot block the arbiter
                asi_in_ready = asi_in_valid & ~asi_in_startofpacket;
                w_orphan_set = asi_in_valid & ~asi_in_startofpacket;
                if (w_any_req) begin
                    w_grant_load = 1'b1;
                    w_state_nxt  = PACKET;
                end
            end
            PACKET: begin
                asi_in_ready = w_out_free ? r_grant_oh : '0;
                if (w_grant_valid && w_out_free) begin
                    w_accept    = 1'b1;
                    w_stall_clr = 1'b1;
                    if (w_grant_eop) begin
                        w_ptr_load  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end else if (!w_grant_valid) begin
                    if (r_stall_cnt == STALL_LAST) begin
                        w_timeout_set = r_grant_oh;
                        w_stall_clr   = 1'b1;
                        w_state_nxt   = ABORT;
                    end else begin
                        w_stall_inc = 1'b1;
                    end
                end
            end
            ABORT: begin
                if (w_out_free) begin
                    w_load_abort = 1'b1;
                    w_ptr_load   = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, pointer, stall counter, output register and sticky flags
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_grant       <= '0;
            r_grant_oh    <= NUM_INPUTS'(1);
            r_rr_ptr      <= '0;
            r_stall_cnt   <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_ch      <= '0;
            r_err_timeout <= '0;
            r_err_orphan  <= '0;
        end else begin
            if (w_grant_load) begin
                r_grant    <= w_arb_idx;
                r_grant_oh <= w_arb_oh;
            end
            if (w_ptr_load) begin
                r_rr_ptr <= (r_grant == LAST_CH) ? '0 : r_grant + CH_W'(1);
            end
            if (w_stall_clr) begin
                r_stall_cnt <= '0;
            end else if (w_stall_inc) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_src_data[r_grant];
                r_out_sop   <= w_grant_sop;
                r_out_eop   <= w_grant_eop;
                r_out_ch    <= r_grant;
            end else if (w_load_abort) begin
                r_out_valid <= 1'b1;
                r_out_data  <= {DATA_WIDTH{ABORT_FILL_BIT}};
                r_out_sop   <= 1'b0;
                r_out_eop   <= 1'b1;
                r_out_ch    <= r_grant;
            end else if (aso_out0_ready) begin
                r_out_valid <= 1'b0;
            end
            if (status_clear) begin
                r_err_timeout <= '0;
                r_err_orphan  <= '0;
            end else begin
                r_err_timeout <= r_err_timeout | w_timeout_set;
                r_err_orphan  <= r_err_orphan | w_orphan_set;
            end
        end
    end

    assign aso_out0_valid         = r_out_valid;
    assign aso_out0_data          = r_out_data;
    assign aso_out0_startofpacket = r_out_sop;
    assign aso_out0_endofpacket   = r_out_eop;
    assign aso_out0_channel       = r_out_ch;
    assign err_timeout            = r_err_timeout;
    assign err_orphan             = r_err_orphan;

endmodule

// File: tb/tb_packet_stream_arbiter.sv
// Directed bench for packet_stream_arbiter: per-source beat queues feed the DUT and a
// handshake monitor collects output beats for checking against hand-computed values.
module tb_packet_stream_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [CW-1:0] ch;
        logic [31:0]   cyc;
    } obeat_t;

    logic            clock_clk;
    logic            reset_reset;
    logic [N*DW-1:0] asi_in_data;
    logic [N-1:0]    asi_in_valid;
    logic [N-1:0]    asi_in_startofpacket;
    logic [N-1:0]    asi_in_endofpacket;
    logic [N-1:0]    asi_in_ready;
    logic [DW-1:0]   aso_out0_data;
    logic            aso_out0_valid;
    logic            aso_out0_ready;
    logic            aso_out0_startofpacket;
    logic            aso_out0_endofpacket;
    logic [CW-1:0]   aso_out0_channel;
    logic [N-1:0]    err_timeout;
    logic [N-1:0]    err_orphan;
    logic            status_clear;

    beat_t  src_q [N][$];
    obeat_t out_q [$];
    int     n_err;
    int     n_chk;
    int     cyc;

    packet_stream_arbiter #(
        .NUM_INPUTS    (N),
        .DATA_WIDTH    (DW),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .asi_in_data            (asi_in_data),
        .asi_in_valid           (asi_in_valid),
        .asi_in_startofpacket   (asi_in_startofpacket),
        .asi_in_endofpacket     (asi_in_endofpacket),
        .asi_in_ready           (asi_in_ready),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .aso_out0_channel       (aso_out0_channel),
        .err_timeout            (err_timeout),
        .err_orphan             (err_orphan),
        .status_clear           (status_clear)
    );

    initial clock_clk = 1'b0;
    always #5 clock_clk = ~clock_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_beat(input int src, input logic [DW-1:0] data, input logic sop, input logic eop);
        beat_t b;
        b.data = data;
        b.sop  = sop;
        b.eop  = eop;
        src_q[src].push_back(b);
    endtask

    task automatic add_pkt(input int src, input int nb, input logic [DW-1:0] base);
        for (int j = 0; j < nb; j++) begin
            add_beat(src, base + DW'(j), j == 0, j == nb - 1);
        end
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: present queue heads, log handshakes before the edge, retire accepted beats after it
    task automatic step();
        logic [N-1:0] acc;
        beat_t        b;
        obeat_t       ob;
        @(negedge clock_clk);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                b = src_q[i][0];
                asi_in_valid[i]            = 1'b1;
                asi_in_startofpacket[i]    = b.sop;
                asi_in_endofpacket[i]      = b.eop;
                asi_in_data[i*DW +: DW]    = b.data;
            end else begin
                asi_in_valid[i]            = 1'b0;
                asi_in_startofpacket[i]    = 1'b0;
                asi_in_endofpacket[i]      = 1'b0;
                asi_in_data[i*DW +: DW]    = '0;
            end
        end
        #1;
        acc = asi_in_valid & asi_in_ready;
        if (aso_out0_valid && aso_out0_ready) begin
            ob.data = aso_out0_data;
            ob.sop  = aso_out0_startofpacket;
            ob.eop  = aso_out0_endofpacket;
            ob.ch   = aso_out0_channel;
            ob.cyc  = 32'(cyc);
            out_q.push_back(ob);
        end
        @(posedge clock_clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input int max_cyc, input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (all_empty() && !aso_out0_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic check_beat(input string tag, input int k, input logic [CW-1:0] ch,
                              input logic [DW-1:0] data, input logic sop, input logic eop);
        logic [31:0] obs;
        if (k < out_q.size()) obs = 32'({out_q[k].ch, out_q[k].sop, out_q[k].eop, out_q[k].data});
        else                  obs = 32'hFFFF_FFFF;
        check($sformatf("%s_beat%0d", tag, k), obs, 32'({ch, sop, eop, data}));
    endtask

    function automatic logic [31:0] beat_cyc(input int k);
        if (k < out_q.size()) return out_q[k].cyc;
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        bit ok;
        n_err                = 0;
        n_chk                = 0;
        cyc                  = 0;
        reset_reset          = 1'b1;
        status_clear         = 1'b0;
        aso_out0_ready       = 1'b1;
        asi_in_valid         = '0;
        asi_in_startofpacket = '0;
        asi_in_endofpacket   = '0;
        asi_in_data          = '0;
        repeat (2) @(posedge clock_clk);
        #1;

        // Reset state
        check("rst_valid",   32'(aso_out0_valid), 32'd0);
        check("rst_sop",     32'(aso_out0_startofpacket), 32'd0);
        check("rst_eop",     32'(aso_out0_endofpacket), 32'd0);
        check("rst_data",    32'(aso_out0_data), 32'd0);
        check("rst_channel", 32'(aso_out0_channel), 32'd0);
        check("rst_err_to",  32'(err_timeout), 32'd0);
        check("rst_err_orp", 32'(err_orphan), 32'd0);
        check("rst_ready",   32'(asi_in_ready), 32'd0);
        @(negedge clock_clk);
        reset_reset = 1'b0;

        // Two simultaneous 3-beat packets: source 0 then source 2, one idle output cycle between
        out_q.delete();
        add_pkt(0, 3, 16'h0010);
        add_pkt(2, 3, 16'h2010);
        drain(40, "t1_drain");
        check("t1_count", 32'(out_q.size()), 32'd6);
        check_beat("t1", 0, 2'd0, 16'h0010, 1'b1, 1'b0);
        check_beat("t1", 1, 2'd0, 16'h0011, 1'b0, 1'b0);
        check_beat("t1", 2, 2'd0, 16'h0012, 1'b0, 1'b1);
        check_beat("t1", 3, 2'd2, 16'h2010, 1'b1, 1'b0);
        check_beat("t1", 4, 2'd2, 16'h2011, 1'b0, 1'b0);
        check_beat("t1", 5, 2'd2, 16'h2012, 1'b0, 1'b1);
        check("t1_throughput", beat_cyc(1) - beat_cyc(0), 32'd1);
        check("t1_gap",        beat_cyc(3) - beat_cyc(2), 32'd2);

        // Source 1 streams three packets; source 3 joins during the first and must win next
        out_q.delete();
        add_pkt(1, 2, 16'h1A00);
        add_pkt(1, 2, 16'h1B00);
        add_pkt(1, 2, 16'h1C00);
        step();
        step();
        add_pkt(3, 2, 16'h3A00);
        drain(60, "t2_drain");
        check("t2_count", 32'(out_q.size()), 32'd8);
        check_beat("t2", 0, 2'd1, 16'h1A00, 1'b1, 1'b0);
        check_beat("t2", 1, 2'd1, 16'h1A01, 1'b0, 1'b1);
        check_beat("t2", 2, 2'd3, 16'h3A00, 1'b1, 1'b0);
        check_beat("t2", 3, 2'd3, 16'h3A01, 1'b0, 1'b1);
        check_beat("t2", 4, 2'd1, 16'h1B00, 1'b1, 1'b0);
        check_beat("t2", 5, 2'd1, 16'h1B01, 1'b0, 1'b1);
        check_beat("t2", 6, 2'd1, 16'h1C00, 1'b1, 1'b0);
        check_beat("t2", 7, 2'd1, 16'h1C01, 1'b0, 1'b1);

        // Sink ready 1,0,0,1 during a 4-beat packet: second beat must hold while stalled
        out_q.delete();
        add_pkt(2, 4, 16'h2C00);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (aso_out0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3_first_valid", 32'(ok), 32'd1);
        aso_out0_ready = 1'b1;
        step();
        aso_out0_ready = 1'b0;
        step();
        check("t3_hold1", 32'({aso_out0_valid, aso_out0_channel, aso_out0_startofpacket,
                               aso_out0_endofpacket, aso_out0_data}),
              32'({1'b1, 2'd2, 1'b0, 1'b0, 16'h2C01}));
        step();
        check("t3_hold2", 32'({aso_out0_valid, aso_out0_channel, aso_out0_startofpacket,
                               aso_out0_endofpacket, aso_out0_data}),
              32'({1'b1, 2'd2, 1'b0, 1'b0, 16'h2C01}));
        aso_out0_ready = 1'b1;
        drain(20, "t3_drain");
        check("t3_count", 32'(out_q.size()), 32'd4);
        check_beat("t3", 0, 2'd2, 16'h2C00, 1'b1, 1'b0);
        check_beat("t3", 1, 2'd2, 16'h2C01, 1'b0, 1'b0);
        check_beat("t3", 2, 2'd2, 16'h2C02, 1'b0, 1'b0);
        check_beat("t3", 3, 2'd2, 16'h2C03, 1'b0, 1'b1);
        check("t3_no_orphan", 32'(err_orphan), 32'd0);

        // Source 0 stalls after SOP: timeout, synthetic EOP, then its tail is discarded
        out_q.delete();
        add_beat(0, 16'h0A01, 1'b1, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (src_q[0].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_sop_taken", 32'(ok), 32'd1);
        repeat (5) step();
        check("t4_no_early_to", 32'(err_timeout), 32'd0);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (err_timeout != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_to_seen", 32'(ok), 32'd1);
        check("t4_err_to", 32'(err_timeout), 32'h1);
        drain(10, "t4_abort_drain");
        check("t4_count", 32'(out_q.size()), 32'd2);
        check_beat("t4", 0, 2'd0, 16'h0A01, 1'b1, 1'b0);
        check_beat("t4", 1, 2'd0, 16'h0000, 1'b0, 1'b1);
        check("t4_orphan_pre", 32'(err_orphan), 32'd0);
        add_beat(0, 16'h0A02, 1'b0, 1'b0);
        add_beat(0, 16'h0A03, 1'b0, 1'b1);
        drain(10, "t4_orphan_drain");
        check("t4_err_orphan", 32'(err_orphan), 32'h1);
        check("t4_count_post", 32'(out_q.size()), 32'd2);

        // Source 3 single beat brings the pointer back to 0
        out_q.delete();
        add_pkt(3, 1, 16'h3D00);
        drain(10, "t4b_drain");
        check_beat("t4b", 0, 2'd3, 16'h3D00, 1'b1, 1'b1);

        // Single-beat packets from every source at once, then clear the sticky flags
        out_q.delete();
        for (int i = 0; i < N; i++) add_pkt(i, 1, 16'h5000 + DW'(i));
        drain(40, "t5_drain");
        check("t5_count", 32'(out_q.size()), 32'd4);
        check_beat("t5", 0, 2'd0, 16'h5000, 1'b1, 1'b1);
        check_beat("t5", 1, 2'd1, 16'h5001, 1'b1, 1'b1);
        check_beat("t5", 2, 2'd2, 16'h5002, 1'b1, 1'b1);
        check_beat("t5", 3, 2'd3, 16'h5003, 1'b1, 1'b1);
        check("t5_sticky", 32'({err_timeout, err_orphan}), 32'h11);
        status_clear = 1'b1;
        step();
        status_clear = 1'b0;
        check("t5_clr_to",  32'(err_timeout), 32'd0);
        check("t5_clr_orp", 32'(err_orphan), 32'd0);

        // Move the pointer to 2, then reset in the middle of a source 2 packet
        out_q.delete();
        add_pkt(1, 1, 16'h1E00);
        drain(10, "t6_pre_drain");
        add_pkt(2, 4, 16'h2E00);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (aso_out0_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("t6_started", 32'(ok), 32'd1);
        step();
        reset_reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(aso_out0_valid), 32'd0);
        check("t6_rst_fields", 32'({aso_out0_channel, aso_out0_startofpacket,
                                    aso_out0_endofpacket, aso_out0_data}), 32'd0);
        for (int i = 0; i < N; i++) src_q[i].delete();
        step();
        step();
        reset_reset = 1'b0;
        out_q.delete();
        add_pkt(0, 2, 16'h0F00);
        add_pkt(2, 2, 16'h2F00);
        drain(30, "t6_drain");
        check("t6_count", 32'(out_q.size()), 32'd4);
        check_beat("t6", 0, 2'd0, 16'h0F00, 1'b1, 1'b0);
        check_beat("t6", 1, 2'd0, 16'h0F01, 1'b0, 1'b1);
        check_beat("t6", 2, 2'd2, 16'h2F00, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/packet_stream_arbiter.md
# packet_stream_arbiter

Round-robin packet arbiter that shares one downstream Avalon-ST packet sink, typically the packet symbol-width adapter, among NUM_INPUTS wide-symbol sources. A grant is held for a whole packet (SOP through EOP), so packets from different sources never interleave. The block tags each output beat with its source index and detects stalled or orphaned traffic through sticky error flags. It sits between the DMA/packet producers and the width adapter's input port.

## Interface
Parameters:
- NUM_INPUTS, 4: number of requesting sources, 2..16.
- DATA_WIDTH, 256: symbol width; must match the adapter's input width.
- STALL_TIMEOUT, 1024: idle cycles tolerated inside a granted packet before that packet is aborted; minimum 2.

Ports (CH_W = max(1, clog2(NUM_INPUTS))):
- clock_clk, in, 1: clock.
- reset_reset, in, 1: asynchronous, active-high reset.
- asi_in_data, in, NUM_INPUTS*DATA_WIDTH: source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- asi_in_valid, in, NUM_INPUTS: per-source valid.
- asi_in_startofpacket, in, NUM_INPUTS: per-source SOP.
- asi_in_endofpacket, in, NUM_INPUTS: per-source EOP.
- asi_in_ready, out, NUM_INPUTS: per-source ready.
- aso_out0_data, out, DATA_WIDTH: forwarded beat.
- aso_out0_valid, out, 1: output valid.
- aso_out0_ready, in, 1: sink ready.
- aso_out0_startofpacket, out, 1: output SOP.
- aso_out0_endofpacket, out, 1: output EOP.
- aso_out0_channel, out, CH_W: source index of the current beat.
- err_timeout, out, NUM_INPUTS: sticky flag; a packet from source i was aborted.
- err_orphan, out, NUM_INPUTS: sticky flag; a non-SOP beat from source i was discarded.
- status_clear, in, 1: single-cycle pulse that clears both error vectors.

## Operation
- States: IDLE, PACKET, ABORT.
- **IDLE**
  - Requesters are sources with valid&&sop.
  - The rr_arbiter picks the first requester at or after pointer rr_ptr (cyclic).
  - On a win: grant <= winner, state <= PACKET. No beat is consumed in IDLE.
  - Orphan discard: asi_in_ready[i] = valid[i] && !sop[i]. These beats are dropped and set err_orphan[i].
- **PACKET**
  - asi_in_ready[grant] = !aso_out0_valid || aso_out0_ready. All other readies are 0.
  - An accepted beat loads the output register with data, sop, eop and channel = grant.
  - An accepted beat with eop: rr_ptr <= grant+1 (mod NUM_INPUTS), state <= IDLE.
  - Stall counter:
    - Increments each PACKET cycle in which valid[grant] is low.
    - Clears on an accepted beat.
    - On reaching STALL_TIMEOUT-1: err_timeout[grant] <= 1, state <= ABORT.
- **ABORT**
  - When the output register is free, emits one beat: data=0, sop=0, eop=1, channel=grant.
  - Then rr_ptr <= grant+1, state <= IDLE.
  - Any remainder of the aborted packet later arrives without SOP and is discarded as orphan.
- A SOP beat arriving mid-packet on the granted source is forwarded unchanged; no error is raised.
- A single-beat packet (sop&&eop) is legal and returns the block to IDLE.
- **status_clear** has priority over setting in the same cycle: the flags clear, and a new error in that cycle is lost.

## Timing
- Output register: 1 cycle latency from input acceptance to aso_out0_valid.
- aso_out0 fields hold stable while valid&&!ready.
- Packet gap: EOP accepted in cycle t, IDLE at t+1, first beat of the next packet accepted at t+2 at the earliest.
- Back-to-back beats within a packet run at full throughput when the sink stays ready.
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, stall counter=0.
  - aso_out0_valid/sop/eop=0, aso_out0_data=0, aso_out0_channel=0.
  - err_timeout=0, err_orphan=0.
  - asi_in_ready: combinational, 0 for every source not presenting a non-SOP valid beat.
- Reset mid-packet abandons the packet with no EOP emitted; the output valid drops on reset assertion.
- asi_in_ready depends combinationally on aso_out0_ready and asi_in_valid/sop. This is documented for integration.

## Structure
- Shared package packet_arb_pkg holds:
  - state enum {IDLE, PACKET, ABORT};
  - function ch_width(n) for CH_W;
  - localparam for the ABORT fill data (0).
- Sub-module rr_arbiter (NUM_INPUTS parameterized):
  - inputs: request vector, pointer;
  - outputs: one-hot grant, encoded index, any_req.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- Sources 0 and 2 both present 3-beat packets at reset release, sink always ready:
  - source 0 is output first, channel=0, then source 2, channel=2;
  - no interleaving; a gap of 1 idle cycle between the packets.
- Source 1 streams continuous packets while source 3 requests once:
  - after source 1's current EOP, source 3 is granted before source 1 again (rotation).
- Sink ready toggles 1,0,0,1 during a 4-beat packet:
  - data/sop/eop/channel hold stable while stalled;
  - all 4 beats are delivered in order, with no duplicates.
- Source 0 sends SOP, then drops valid for STALL_TIMEOUT cycles:
  - err_timeout[0]=1;
  - one zero-data beat with eop=1, channel=0 is emitted;
  - source 0's later non-SOP beats are discarded with err_orphan[0]=1.
- Single-beat sop&&eop packets from all 4 sources simultaneously:
  - output channels 0,1,2,3, each beat with sop=eop=1;
  - status_clear afterwards leaves all error flags 0.
- Reset asserted in the middle of the 2nd beat of a packet:
  - aso_out0_valid drops immediately;
  - after release, source 0 is granted first (rr_ptr=0).
